uart_rx_buffer: RTL
===================

Name: uart_rx_buffer

Overview:
- Serial receive front-end for one UART channel: 8N1 deserializer on the `rx` line plus a byte FIFO.
- Sits upstream of the UART write-back path. The UART read instruction pops one byte per `rd_en`; the popped byte becomes `UART_write_back_value[7:0]`.
- Decouples asynchronous serial arrival from the slow virtual CPU clock, so bytes are not lost between instructions.
- Runs entirely on the 50 MHz physical clock.

Parameters:
- CLKS_PER_BIT, 434, `physical_clock` cycles per serial bit (50 MHz / 115200). Minimum 4.
- ADDR_W, 4, FIFO address width. FIFO depth is 2**ADDR_W (16).

Ports:
- physical_clock  in  1  system clock; all logic on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high; asynchronous to `physical_clock`.
- rd_en  in  1  pop request, 1-cycle pulse.
- rd_data  out  8  popped byte.
- rd_valid  out  1  1-cycle pulse: `rd_data` was updated this cycle.
- empty  out  1  FIFO holds 0 bytes.
- full  out  1  FIFO holds 2**ADDR_W bytes.
- count  out  ADDR_W+1  number of bytes stored.
- frame_err  out  1  1-cycle pulse: byte discarded because the stop bit sampled low.
- overrun  out  1  1-cycle pulse: valid byte discarded because the FIFO was full.
- busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset (async assert, sync release) sets:
  - `rd_data`=0, `rd_valid`=0, `empty`=1, `full`=0, `count`=0
  - `frame_err`=0, `overrun`=0, `busy`=0
  - FSM=IDLE; read/write pointers=0
  - synchronizer flops=1
- Reset mid-frame aborts the frame and clears the FIFO; no partial byte is pushed.
- Input path: `rx` passes through a 2-flop synchronizer; all sampling uses the synchronized value `rxs`.
- Bit counter `baud_cnt` runs 0..CLKS_PER_BIT-1. Bit index `bit_idx` is 3 bits.
- FSM:
  - IDLE: `rxs`==0 → START, `baud_cnt`=0.
  - START: at `baud_cnt`==CLKS_PER_BIT/2-1 (mid start bit), sample `rxs`.
    - 0 → DATA, `baud_cnt`=0, `bit_idx`=0.
    - 1 → IDLE (glitch rejected, nothing reported).
  - DATA: at `baud_cnt`==CLKS_PER_BIT-1, shift `rxs` into `shreg[bit_idx]` (LSB first) and reset `baud_cnt`.
    - After `bit_idx`==7 → STOP (or PARITY when the optional feature is compiled in).
  - STOP: at `baud_cnt`==CLKS_PER_BIT-1, sample `rxs`.
    - 1 and not full → push `shreg`.
    - 1 and full → `overrun` pulse.
    - 0 → `frame_err` pulse.
    - In all cases → IDLE in the same cycle. This allows back-to-back frames from mid-stop-bit.
- `busy`=1 in every state except IDLE.
- FIFO:
  - Write pointer and read pointer are ADDR_W bits and wrap modulo 2**ADDR_W.
  - `count` is updated as +1 on push only, -1 on pop only, unchanged on both.
  - `empty` = (`count`==0); `full` = (`count`==2**ADDR_W). Both are derived from the registered `count`.
- Pop:
  - `rd_en` while `count`>0: `rd_data` <= mem[`rd_ptr`] and `rd_valid`=1 in the next cycle (1-cycle latency); `rd_ptr` increments.
  - `rd_en` while empty: ignored; `rd_valid`=0, `rd_data` holds its value.
- Simultaneous push and pop:
  - Both are performed.
  - When full at that cycle, the push is still accepted, because the pop frees the slot in the same edge. Fullness for the overrun decision = `full` && !(`rd_en` && !`empty`).
  - When empty at that cycle, the pop is ignored and the push proceeds; the byte is not bypassed to `rd_data`.
- `frame_err` and `overrun` never assert in the same cycle. A byte pushed in cycle N is readable by `rd_en` in cycle N+1.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampling one even-parity bit at mid-bit.
  - Adds output `parity_err` (1 bit, reset 0): 1-cycle pulse at the stop sample when the XOR of the 8 data bits and the parity bit is 1. The byte is discarded (not pushed).
  - A frame with both a parity error and a low stop bit reports `frame_err` only.
- Undefined: no PARITY state, no `parity_err` port; the frame is 10 bits.

Test Plan (bench uses CLKS_PER_BIT=8, ADDR_W=2):
- Single byte: send 0xA5 8N1 → `count` becomes 1 about 76 cycles after the start edge; `rd_en` → next cycle `rd_valid`=1, `rd_data`=0xA5, `empty`=1.
- Glitch: drive `rx` low for 2 cycles, then high → FSM returns to IDLE, `count`=0, no error pulses.
- Framing error: send 0x3C with the stop bit held low → one `frame_err` pulse, `count`=0; a following frame 0x11 is received correctly.
- Overflow and wrap:
  - Send 0x01..0x05 with no reads → `full`=1 after 0x04 and one `overrun` pulse on 0x05.
  - Pop 4 → 0x01, 0x02, 0x03, 0x04.
  - Send 0x06, 0x07 → popped as 0x06, 0x07 after the pointer wrap.
- Simultaneous: with the FIFO full, assert `rd_en` in the exact stop-sample cycle of 0x55 → no `overrun`, `count` stays 4, 0x55 is the last byte popped.
- Reset mid-frame: assert `n_reset` low during bit 3 of 0x99 with 2 bytes stored → `count`=0, `empty`=1, `busy`=0 immediately; after release the next byte 0x42 is received normally.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a byte FIFO; pop latency 1 cycle (rd_en -> rd_valid/rd_data).
// Backpressure: none toward the line -- a good byte arriving while full is dropped with an overrun pulse.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic              physical_clock,
    input  logic              n_reset,
    input  logic              rx,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              frame_err,
    output logic              overrun,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int            DEPTH   = 2 ** ADDR_W;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic              rx_meta;
    logic              rxs;
    logic [2:0]        state;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic stop_tick;
    logic par_ok;
    logic good_stop;
    logic pop;
    logic push;
    logic ovr;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = ~(^{shreg, par_bit});
`else
    assign par_ok = 1'b1;
`endif

    // A pop in the same edge frees a slot, so a full FIFO can still accept the byte.
    assign stop_tick = (state == S_STOP) && (baud_cnt == BIT_END);
    assign good_stop = stop_tick && rxs && par_ok;
    assign pop       = rd_en && !empty;
    assign push      = good_stop && !(full && !pop);
    assign ovr       = good_stop && full && !pop;

    assign empty = (count == '0);
    assign full  = (count == (ADDR_W + 1)'(DEPTH));
    assign busy  = (state != S_IDLE);

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (baud_cnt == HALF) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt       <= '0;
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        par_bit  <= rxs;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_tick && !rxs;
            overrun   <= ovr;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_tick && rxs && !par_ok;
`endif
        end
    end

    always_ff @(posedge physical_clock) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
